dcache_ctrl: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache controller between the CPU's EX/MEM stage and the 256-bit off-chip data memory.
- Accepts 32-bit word loads/stores from the pipeline and raises a stall while a miss is serviced.
- Owns tag/valid/dirty state and line storage, and drives the single-outstanding-request memory handshake (enable held until ack).

---
 rtl/dcache_ctrl.sv | 144 ++++++++++++++
 tb/tb_dcache_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
module dcache_ctrl #(
    parameter int NUM_LINES = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  p1_addr_i,
    input  logic [31:0]  p1_data_i,
    input  logic         p1_MemRead_i,
    input  logic         p1_MemWrite_i,
    output logic [31:0]  p1_data_o,
    output logic         p1_stall_o,
    input  logic [255:0] mem_data_i,
    input  logic         mem_ack_i,
    output logic [255:0] mem_data_o,
    output logic [31:0]  mem_addr_o,
    output logic         mem_enable_o,
    output logic         mem_write_o
);
    localparam int LINE_BITS = 256;
    localparam int IDX_W     = $clog2(NUM_LINES);
    localparam int TAG_W     = 27 - IDX_W;

    typedef enum logic [2:0] {
        IDLE, MISS, WRITEBACK, READMISS, READMISSOK
    } state_t;

    state_t state_q, state_d;

    logic [LINE_BITS-1:0] data_q [NUM_LINES];
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;

    // Line address of the request being serviced, captured when the miss is detected
    logic [26:0]          line_addr_q;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [2:0]       req_word;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;
    logic             req;
    logic             hit;
    logic             store_hit;
    logic             fill;
    logic             unused_addr_bits;

    assign req_tag   = p1_addr_i[31:5+IDX_W];
    assign req_idx   = p1_addr_i[4+IDX_W:5];
    assign req_word  = p1_addr_i[4:2];
    assign miss_tag  = line_addr_q[26:IDX_W];
    assign miss_idx  = line_addr_q[IDX_W-1:0];
    assign req       = p1_MemRead_i | p1_MemWrite_i;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign store_hit = (state_q == IDLE) && p1_MemWrite_i && hit;
    assign fill      = (state_q == READMISS) && mem_ack_i;
    assign unused_addr_bits = ^p1_addr_i[1:0];

    // State register, miss address and valid/dirty bits; reset invalidates every line
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            line_addr_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req && !hit) begin
                line_addr_q <= p1_addr_i[31:5];
            end
            if (fill) begin
                valid_q[miss_idx] <= 1'b1;
                dirty_q[miss_idx] <= 1'b0;
            end else if (store_hit) begin
                dirty_q[req_idx] <= 1'b1;
            end
        end
    end

    // Line data and tags: whole-line refill on ack, single-word update on a store hit
    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[miss_idx] <= mem_data_i;
            tag_q[miss_idx]  <= miss_tag;
        end else if (store_hit) begin
            data_q[req_idx][{req_word, 5'b00000} +: 32] <= p1_data_i;
        end
    end

    // Next state and outputs; memory side depends only on state and registered values
    always_comb begin
        state_d      = state_q;
        p1_stall_o   = 1'b0;
        p1_data_o    = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        if (p1_MemRead_i && !p1_MemWrite_i) begin
                            p1_data_o = data_q[req_idx][{req_word, 5'b00000} +: 32];
                        end
                    end else begin
                        p1_stall_o = 1'b1;
                        state_d    = MISS;
                    end
                end
            end
            MISS: begin
                p1_stall_o = 1'b1;
                state_d    = (valid_q[miss_idx] && dirty_q[miss_idx]) ? WRITEBACK : READMISS;
            end
            WRITEBACK: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {tag_q[miss_idx], miss_idx, 5'b00000};
                mem_data_o   = data_q[miss_idx];
                if (mem_ack_i) begin
                    state_d = READMISS;
                end
            end
            READMISS: begin
                p1_stall_o   = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {line_addr_q, 5'b00000};
                if (mem_ack_i) begin
                    state_d = READMISSOK;
                end
            end
            READMISSOK: begin
                p1_stall_o = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard testbench for dcache_ctrl
module tb_dcache_ctrl;
    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [31:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic         rd = 1'b0;
    logic         wr = 1'b0;
    logic [255:0] mrdata = '0;
    logic         ack = 1'b0;
    logic [31:0]  p1_data_o;
    logic         p1_stall_o;
    logic [255:0] mem_data_o;
    logic [31:0]  mem_addr_o;
    logic         mem_enable_o;
    logic         mem_write_o;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    dcache_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .p1_addr_i    (addr),
        .p1_data_i    (wdata),
        .p1_MemRead_i (rd),
        .p1_MemWrite_i(wr),
        .p1_data_o    (p1_data_o),
        .p1_stall_o   (p1_stall_o),
        .mem_data_i   (mrdata),
        .mem_ack_i    (ack),
        .mem_data_o   (mem_data_o),
        .mem_addr_o   (mem_addr_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o)
    );

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = base + 32'(i);
        return r;
    endfunction

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; wdata = d;
    endtask

    // Memory responder: waits for a request, holds ack off for lat cycles, then pulses ack
    task automatic serve(input int lat, input logic [255:0] rline, output logic found,
                         output logic w, output logic [31:0] a, output logic [255:0] d,
                         output logic stable, output int wait_cyc);
        found = 1'b0; stable = 1'b1; w = 1'b0; a = '0; d = '0; wait_cyc = 0;
        while (!found && wait_cyc < 20) begin
            @(negedge clk);
            if (mem_enable_o === 1'b1) found = 1'b1;
            else wait_cyc++;
        end
        if (!found) return;
        w = mem_write_o; a = mem_addr_o; d = mem_data_o;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if ({mem_enable_o, mem_write_o, mem_addr_o, mem_data_o} !== {1'b1, w, a, d}) stable = 1'b0;
        end
        @(posedge clk);
        #1;
        ack = 1'b1; mrdata = rline;
        @(negedge clk);
        if ({mem_enable_o, mem_write_o, mem_addr_o, mem_data_o} !== {1'b1, w, a, d}) stable = 1'b0;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p1_data_o} !== 67'd0)
            $display("FAIL reset_outs stall=%0b en=%0b wr=%0b addr=%h data=%h expected all 0",
                     p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, p1_data_o);
        else n_pass++;
        n_total++;
        if (mem_data_o !== 256'd0) $display("FAIL reset_mem_data got %h expected 0", mem_data_o);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_load_miss();
        logic f, w, s; logic [31:0] a, exp; logic [255:0] d, l; int wc;
        drive(1, 0, 32'h0000_0004, 0);
        sb.push_back(32'hDEADBEEF);
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o} !== 2'b10) $display("FAIL t1_stall_now stall=%0b en=%0b expected 1/0", p1_stall_o, mem_enable_o);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o} !== 2'b10) $display("FAIL t1_miss_cycle stall=%0b en=%0b expected 1/0", p1_stall_o, mem_enable_o);
        else n_pass++;
        l = mk_line(32'hA000_0000);
        l[63:32] = 32'hDEADBEEF;
        serve(10, l, f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s} !== {1'b1, 1'b0, 32'h0, 1'b1} || wc != 0)
            $display("FAIL t1_refill_req found=%0b wr=%0b addr=%h stable=%0b wait=%0d expected 1/0/00000000/1/0", f, w, a, s, wc);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o} !== 2'b10) $display("FAIL t1_ack_plus1 stall=%0b en=%0b expected 1/0", p1_stall_o, mem_enable_o);
        else n_pass++;
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t1_load_data stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_store_hit();
        logic [31:0] exp;
        drive(0, 1, 32'h0000_0008, 32'h1234_5678);
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o} !== 2'b00) $display("FAIL t2_store_hit stall=%0b en=%0b expected 0/0", p1_stall_o, mem_enable_o);
        else n_pass++;
        drive(1, 0, 32'h0000_0008, 0);
        sb.push_back(32'h1234_5678);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t2_load_back stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_dirty_evict();
        logic f, w, s; logic [31:0] a, exp; logic [255:0] d, victim; int wc;
        victim = mk_line(32'hA000_0000);
        victim[63:32] = 32'hDEADBEEF;
        victim[95:64] = 32'h1234_5678;
        drive(1, 0, 32'h0000_0400, 0);
        sb.push_back(32'hB000_0000);
        @(negedge clk);
        n_total++;
        if (p1_stall_o !== 1'b1) $display("FAIL t3_stall got %0b expected 1", p1_stall_o);
        else n_pass++;
        serve(4, '0, f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s} !== {1'b1, 1'b1, 32'h0, 1'b1})
            $display("FAIL t3_writeback found=%0b wr=%0b addr=%h stable=%0b expected 1/1/00000000/1", f, w, a, s);
        else n_pass++;
        n_total++;
        if (d[95:64] !== 32'h1234_5678) $display("FAIL t3_wb_word2 got %h expected 12345678", d[95:64]);
        else n_pass++;
        n_total++;
        if (d !== victim) $display("FAIL t3_wb_line got %h expected %h", d, victim);
        else n_pass++;
        serve(3, mk_line(32'hB000_0000), f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s} !== {1'b1, 1'b0, 32'h400, 1'b1} || wc != 0)
            $display("FAIL t3_refill found=%0b wr=%0b addr=%h stable=%0b wait=%0d expected 1/0/00000400/1/0", f, w, a, s, wc);
        else n_pass++;
        repeat (2) @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t3_load_data stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_clean_miss_rw();
        logic f, w, s; logic [31:0] a, exp; logic [255:0] d, victim; int wc;
        drive(1, 0, 32'h0000_0020, 0);
        sb.push_back(32'hC000_0000);
        @(negedge clk);
        serve(3, mk_line(32'hC000_0000), f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s} !== {1'b1, 1'b0, 32'h20, 1'b1})
            $display("FAIL t4_clean_read found=%0b wr=%0b addr=%h stable=%0b expected 1/0/00000020/1", f, w, a, s);
        else n_pass++;
        repeat (2) @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t4_load_data stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(1, 1, 32'h0000_0024, 32'h55AA_55AA);
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, mem_enable_o} !== 2'b00) $display("FAIL t4_rw_store stall=%0b en=%0b expected 0/0", p1_stall_o, mem_enable_o);
        else n_pass++;
        drive(1, 0, 32'h0000_0024, 0);
        sb.push_back(32'h55AA_55AA);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t4_rw_load stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        victim = mk_line(32'hC000_0000);
        victim[63:32] = 32'h55AA_55AA;
        drive(1, 0, 32'h0000_0420, 0);
        sb.push_back(32'hD000_0000);
        @(negedge clk);
        serve(2, '0, f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s, d} !== {1'b1, 1'b1, 32'h20, 1'b1, victim})
            $display("FAIL t4_dirty_wb found=%0b wr=%0b addr=%h stable=%0b data=%h", f, w, a, s, d);
        else n_pass++;
        serve(1, mk_line(32'hD000_0000), f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a} !== {1'b1, 1'b0, 32'h420}) $display("FAIL t4_refill2 found=%0b wr=%0b addr=%h expected 1/0/00000420", f, w, a);
        else n_pass++;
        repeat (2) @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t4_load2 stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_reset_in_flight();
        logic f, w, s; logic [31:0] a, exp; logic [255:0] d; int wc;
        logic seen;
        seen = 1'b0;
        drive(1, 0, 32'h0000_0840, 0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_enable_o === 1'b1) seen = 1'b1;
        end
        n_total++;
        if (seen !== 1'b1) $display("FAIL t5_enable_seen got %0b expected 1", seen);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        rd = 1'b0;
        #1;
        n_total++;
        if ({mem_enable_o, mem_write_o, mem_addr_o, p1_stall_o} !== 35'd0)
            $display("FAIL t5_async_abort en=%0b wr=%0b addr=%h stall=%0b expected all 0", mem_enable_o, mem_write_o, mem_addr_o, p1_stall_o);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, 0, 32'h0000_0404, 0);
        sb.push_back(32'hE000_0001);
        @(negedge clk);
        n_total++;
        if (p1_stall_o !== 1'b1) $display("FAIL t5_remiss got stall=%0b expected 1", p1_stall_o);
        else n_pass++;
        serve(2, mk_line(32'hE000_0000), f, w, a, d, s, wc);
        n_total++;
        if ({f, w, a, s} !== {1'b1, 1'b0, 32'h400, 1'b1})
            $display("FAIL t5_clean_refill found=%0b wr=%0b addr=%h stable=%0b expected 1/0/00000400/1", f, w, a, s);
        else n_pass++;
        repeat (2) @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t5_load_data stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_stray_ack();
        logic [31:0] exp;
        drive(0, 0, 0, 0);
        ack = 1'b1;
        mrdata = {8{32'hFFFF_FFFF}};
        @(posedge clk);
        #1 ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if ({p1_stall_o, mem_enable_o, p1_data_o} !== 34'd0)
                $display("FAIL t6_idle_quiet stall=%0b en=%0b data=%h expected 0/0/0", p1_stall_o, mem_enable_o, p1_data_o);
            else n_pass++;
        end
        drive(1, 0, 32'h0000_0404, 0);
        sb.push_back(32'hE000_0001);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL t6_array_intact stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        drive(0, 1, 32'h0000_0408, 32'h0BAD_F00D);
        @(negedge clk);
        n_total++;
        if (p1_stall_o !== 1'b0) $display("FAIL b2b_store stall=%0b expected 0", p1_stall_o);
        else n_pass++;
        drive(1, 0, 32'h0000_0408, 0);
        sb.push_back(32'h0BAD_F00D);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL b2b_load1 stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(1, 0, 32'h0000_040C, 0);
        sb.push_back(32'hE000_0003);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        n_total++;
        if ({p1_stall_o, p1_data_o} !== {1'b0, exp}) $display("FAIL b2b_load2 stall=%0b data=%h expected 0/%h", p1_stall_o, p1_data_o, exp);
        else n_pass++;
        drive(0, 0, 0, 0);
        @(negedge clk);
        n_total++;
        if ({p1_stall_o, p1_data_o} !== 33'd0) $display("FAIL b2b_no_req stall=%0b data=%h expected 0/0", p1_stall_o, p1_data_o);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_store_hit();
        test_dirty_evict();
        test_clean_miss_rw();
        test_reset_in_flight();
        test_stray_ack();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
